// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: assembles channel messages into packed words,
// queues them in a show-ahead FIFO and holds the most recent one.
module midi_msg_parser #(
   parameter int FIFO_DEPTH          = 4,
   parameter bit NOTE_ON_ZERO_AS_OFF = 1'b1,
   localparam int AW = $clog2(FIFO_DEPTH),
   localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          byte_valid,
   input  logic [7:0]    byte_data,
   input  logic          msg_pop,
   input  logic          clr_overflow,
   output logic          msg_valid,
   output logic [31:0]   msg_data,
   output logic [CW-1:0] msg_count,
   output logic [31:0]   last_msg,
   output logic          overflow
);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_D1,
      WAIT_D2,
      SYSEX
   } state_t;

   state_t        state;
   logic [7:0]    rs;
   logic          need2;
   logic [7:0]    d1;
   logic [31:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   logic          is_rt;
   logic          is_sx;
   logic          is_sys;
   logic          is_chan;
   logic          is_data;
   logic          emit;
   logic [7:0]    d1v;
   logic [7:0]    d2v;
   logic [7:0]    st;
   logic [31:0]   emit_msg;
   logic          full;
   logic          pop;
   logic          push;
   logic          drop;

   assign is_rt   = &byte_data[7:3];
   assign is_sx   = byte_data == 8'hF0;
   assign is_sys  = byte_data[7:4] == 4'hF && !is_rt && !is_sx;
   assign is_chan = byte_data[7] && byte_data[7:4] != 4'hF;
   assign is_data = !byte_data[7];

   assign emit = byte_valid && is_data &&
                 ((state == WAIT_D1 && !need2) || state == WAIT_D2);

   assign d1v = (state == WAIT_D2) ? d1 : byte_data;
   assign d2v = (state == WAIT_D2) ? byte_data : 8'h00;

   // Velocity-zero Note On is reported as Note Off; rs keeps the 9n status.
   always_comb begin
      st = rs;
      if (NOTE_ON_ZERO_AS_OFF && rs[7:4] == 4'h9 && d2v == 8'h00)
         st = {4'h8, rs[3:0]};
   end

   assign emit_msg = {8'h00, st, d1v, d2v};

   assign full      = msg_count == CW'(FIFO_DEPTH);
   assign msg_valid = msg_count != '0;
   assign msg_data  = msg_valid ? mem[rd_ptr] : 32'h0;
   assign pop       = msg_pop && msg_valid;
   assign push      = emit && (!full || pop);
   assign drop      = emit && full && !pop;

   always_ff @(posedge clock) begin
      if (push)
         mem[wr_ptr] <= emit_msg;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state     <= IDLE;
         rs        <= 8'h00;
         need2     <= 1'b0;
         d1        <= 8'h00;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         msg_count <= '0;
         last_msg  <= 32'h0;
         overflow  <= 1'b0;
      end else begin
         if (byte_valid) begin
            unique case (1'b1)
               is_rt: ;
               is_chan: begin
                  rs    <= byte_data;
                  need2 <= !(byte_data[7:4] == 4'hC ||
                             byte_data[7:4] == 4'hD);
                  state <= WAIT_D1;
               end
               is_sx: begin
                  rs    <= 8'h00;
                  state <= SYSEX;
               end
               is_sys: begin
                  rs    <= 8'h00;
                  state <= IDLE;
               end
               is_data: begin
                  case (state)
                     WAIT_D1: begin
                        if (need2) begin
                           d1    <= byte_data;
                           state <= WAIT_D2;
                        end
                     end
                     WAIT_D2: state <= WAIT_D1;
                     default: ;
                  endcase
               end
            endcase
         end

         if (emit)
            last_msg <= emit_msg;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         if (push)
            wr_ptr <= wr_ptr + 1'b1;

         case ({push, pop})
            2'b10:   msg_count <= msg_count + 1'b1;
            2'b01:   msg_count <= msg_count - 1'b1;
            default: ;
         endcase

         if (drop)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

endmodule

// File: tb/tb_midi_msg_parser.sv
// Directed bench for midi_msg_parser; a second instance covers the
// variant that keeps velocity-zero Note On as 9n.
module tb_midi_msg_parser;

   logic        clk;
   logic        reset;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        msg_pop;
   logic        clr_overflow;

   logic        msg_valid,  msg_valid0;
   logic [31:0] msg_data,   msg_data0;
   logic [2:0]  msg_count,  msg_count0;
   logic [31:0] last_msg,   last_msg0;
   logic        overflow,   overflow0;

   int vectors = 0;
   int errors  = 0;

   midi_msg_parser #(.FIFO_DEPTH(4), .NOTE_ON_ZERO_AS_OFF(1'b1)) dut (
      .clock(clk), .reset(reset),
      .byte_valid(byte_valid), .byte_data(byte_data),
      .msg_pop(msg_pop), .clr_overflow(clr_overflow),
      .msg_valid(msg_valid), .msg_data(msg_data),
      .msg_count(msg_count), .last_msg(last_msg),
      .overflow(overflow)
   );

   midi_msg_parser #(.FIFO_DEPTH(4), .NOTE_ON_ZERO_AS_OFF(1'b0)) dut0 (
      .clock(clk), .reset(reset),
      .byte_valid(byte_valid), .byte_data(byte_data),
      .msg_pop(msg_pop), .clr_overflow(clr_overflow),
      .msg_valid(msg_valid0), .msg_data(msg_data0),
      .msg_count(msg_count0), .last_msg(last_msg0),
      .overflow(overflow0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drivers are entered and left on a negedge; outputs are then settled.
   task automatic put(input logic [7:0] b);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic pop1();
      msg_pop = 1'b1;
      @(negedge clk);
      msg_pop = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_reset();
      do_reset();
      vectors++;
      if ({msg_valid, msg_count, overflow} !== 5'b0) begin
         errors++;
         $display("FAIL reset_flags got %b exp 00000",
                  {msg_valid, msg_count, overflow});
      end
      vectors++;
      if ({msg_data, last_msg} !== 64'h0) begin
         errors++;
         $display("FAIL reset_words got %h %h exp 0 0", msg_data, last_msg);
      end
   endtask

   task automatic test_note_on();
      do_reset();
      put(8'h90);
      put(8'h3C);
      vectors++;
      if (msg_valid !== 1'b0) begin
         errors++;
         $display("FAIL note_early got %b exp 0", msg_valid);
      end
      put(8'h64);
      vectors++;
      if (msg_valid !== 1'b1 || msg_count !== 3'd1) begin
         errors++;
         $display("FAIL note_valid got %b/%0d exp 1/1", msg_valid, msg_count);
      end
      vectors++;
      if (msg_data !== 32'h00903C64 || last_msg !== 32'h00903C64) begin
         errors++;
         $display("FAIL note_data got %h %h exp 00903c64", msg_data, last_msg);
      end
      pop1();
      vectors++;
      if (msg_valid !== 1'b0 || msg_data !== 32'h0 ||
          last_msg !== 32'h00903C64) begin
         errors++;
         $display("FAIL note_pop got %b %h %h exp 0 0 00903c64",
                  msg_valid, msg_data, last_msg);
      end
   endtask

   task automatic test_running_status();
      do_reset();
      put(8'h90); put(8'h3C); put(8'h64); put(8'h40); put(8'h00);
      vectors++;
      if (msg_count !== 3'd2 || msg_count0 !== 3'd2) begin
         errors++;
         $display("FAIL rs_count got %0d %0d exp 2 2", msg_count, msg_count0);
      end
      vectors++;
      if (msg_data !== 32'h00903C64 || msg_data0 !== 32'h00903C64) begin
         errors++;
         $display("FAIL rs_head1 got %h %h exp 00903c64", msg_data, msg_data0);
      end
      pop1();
      vectors++;
      if (msg_data !== 32'h00804000 || last_msg !== 32'h00804000) begin
         errors++;
         $display("FAIL rs_zero_off got %h %h exp 00804000",
                  msg_data, last_msg);
      end
      vectors++;
      if (msg_data0 !== 32'h00904000 || last_msg0 !== 32'h00904000) begin
         errors++;
         $display("FAIL rs_zero_keep got %h %h exp 00904000",
                  msg_data0, last_msg0);
      end
   endtask

   task automatic test_realtime();
      do_reset();
      put(8'h90); put(8'hF8); put(8'h3C); put(8'hFE); put(8'h64);
      vectors++;
      if (msg_count !== 3'd1 || msg_data !== 32'h00903C64) begin
         errors++;
         $display("FAIL realtime got %0d %h exp 1 00903c64",
                  msg_count, msg_data);
      end
   endtask

   task automatic test_sysex();
      do_reset();
      put(8'hC5); put(8'h07); put(8'h08);
      put(8'hF0); put(8'h7E); put(8'h01); put(8'hF7); put(8'h45);
      vectors++;
      if (msg_count !== 3'd2 || last_msg !== 32'h00C50800) begin
         errors++;
         $display("FAIL sysex_skip got %0d %h exp 2 00c50800",
                  msg_count, last_msg);
      end
      put(8'hE0); put(8'h00); put(8'h40);
      vectors++;
      if (msg_count !== 3'd3 || last_msg !== 32'h00E00040) begin
         errors++;
         $display("FAIL sysex_bend got %0d %h exp 3 00e00040",
                  msg_count, last_msg);
      end
      vectors++;
      if (msg_data !== 32'h00C50700) begin
         errors++;
         $display("FAIL sysex_h0 got %h exp 00c50700", msg_data);
      end
      pop1();
      vectors++;
      if (msg_data !== 32'h00C50800) begin
         errors++;
         $display("FAIL sysex_h1 got %h exp 00c50800", msg_data);
      end
      pop1();
      vectors++;
      if (msg_data !== 32'h00E00040) begin
         errors++;
         $display("FAIL sysex_h2 got %h exp 00e00040", msg_data);
      end
      pop1();
      vectors++;
      if (msg_valid !== 1'b0) begin
         errors++;
         $display("FAIL sysex_empty got %b exp 0", msg_valid);
      end
   endtask

   task automatic test_overflow();
      logic [31:0] exp_q [4];
      exp_q = '{32'h00903C02, 32'h00903C03, 32'h00903C04, 32'h00903C06};
      do_reset();
      put(8'h90);
      for (int i = 1; i <= 4; i++) begin
         put(8'h3C);
         put(8'(i));
      end
      vectors++;
      if (msg_count !== 3'd4 || overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_fill got %0d %b exp 4 0", msg_count, overflow);
      end
      put(8'h3C); put(8'h05);
      vectors++;
      if (msg_count !== 3'd4 || overflow !== 1'b1) begin
         errors++;
         $display("FAIL ovf_drop got %0d %b exp 4 1", msg_count, overflow);
      end
      vectors++;
      if (msg_data !== 32'h00903C01 || last_msg !== 32'h00903C05) begin
         errors++;
         $display("FAIL ovf_words got %h %h exp 00903c01 00903c05",
                  msg_data, last_msg);
      end
      put(8'h3C);
      msg_pop = 1'b1;
      put(8'h06);
      msg_pop = 1'b0;
      vectors++;
      if (msg_count !== 3'd4 || overflow !== 1'b1 ||
          msg_data !== 32'h00903C02) begin
         errors++;
         $display("FAIL ovf_popush got %0d %b %h exp 4 1 00903c02",
                  msg_count, overflow, msg_data);
      end
      put(8'h3C);
      clr_overflow = 1'b1;
      put(8'h07);
      clr_overflow = 1'b0;
      vectors++;
      if (overflow !== 1'b1 || last_msg !== 32'h00903C07 ||
          msg_data !== 32'h00903C02) begin
         errors++;
         $display("FAIL ovf_setwins got %b %h %h exp 1 00903c07 00903c02",
                  overflow, last_msg, msg_data);
      end
      clr_overflow = 1'b1;
      @(negedge clk);
      clr_overflow = 1'b0;
      vectors++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL ovf_clear got %b exp 0", overflow);
      end
      for (int i = 0; i < 4; i++) begin
         vectors++;
         if (msg_data !== exp_q[i]) begin
            errors++;
            $display("FAIL ovf_drain%0d got %h exp %h", i, msg_data, exp_q[i]);
         end
         pop1();
      end
      vectors++;
      if (msg_count !== 3'd0 || msg_data !== 32'h0) begin
         errors++;
         $display("FAIL ovf_empty got %0d %h exp 0 0", msg_count, msg_data);
      end
   endtask

   task automatic test_back_to_back();
      do_reset();
      put(8'h90); put(8'h3C); put(8'h11);
      put(8'h3C);
      msg_pop = 1'b1;
      put(8'h22);
      msg_pop = 1'b0;
      vectors++;
      if (msg_count !== 3'd1 || msg_data !== 32'h00903C22) begin
         errors++;
         $display("FAIL b2b_one got %0d %h exp 1 00903c22",
                  msg_count, msg_data);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      put(8'h90); put(8'h3C);
      do_reset();
      put(8'h64);
      vectors++;
      if ({msg_valid, msg_count, overflow} !== 5'b0 ||
          {msg_data, last_msg} !== 64'h0) begin
         errors++;
         $display("FAIL reset_mid got %b %0d %b %h %h exp all 0",
                  msg_valid, msg_count, overflow, msg_data, last_msg);
      end
   endtask

   initial begin
      reset        = 1'b0;
      byte_valid   = 1'b0;
      byte_data    = 8'h00;
      msg_pop      = 1'b0;
      clr_overflow = 1'b0;
      @(negedge clk);
      test_reset();
      test_note_on();
      test_running_status();
      test_realtime();
      test_sysex();
      test_overflow();
      test_back_to_back();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
